pll_phase_shift_sequencer: RTL and testbench

PLL_PHASE_SHIFT_SEQUENCER -- requirements
Module: pll_phase_shift_sequencer

---
 rtl/pll_phase_shift_sequencer_pkg.sv | 30 +++
 rtl/pll_phase_shift_sequencer_phasedone.sv | 25 ++
 rtl/pll_phase_shift_sequencer.sv | 151 +++++++++++++++
 tb/tb_pll_phase_shift_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_phase_shift_sequencer_pkg.sv
// Shared definitions for the PLL phase-shift sequencer:
//   - default parameter values
//   - sequencer state enum and its encoding width
//   - cnt_w(): counter width helper that never returns zero
package pll_phase_shift_sequencer_pkg;

  localparam int DEF_PLL_COUNT = 4;
  localparam int DEF_STEP_W    = 8;
  localparam int DEF_SEL_W     = 3;
  localparam int DEF_STEP_HOLD = 2;
  localparam int DEF_TIMEOUT   = 255;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_STEP      = 3'd1,
    S_WAIT_LOW  = 3'd2,
    S_WAIT_HIGH = 3'd3,
    S_NEXT      = 3'd4,
    S_FINISH    = 3'd5,
    S_FAIL      = 3'd6
  } state_e;

  // Width of a counter/index that must hold values 0..n-1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_phase_shift_sequencer_phasedone.sv
// phasedone_sync: 2-flop synchroniser for one asynchronous phasedone bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronised output (2 cycles of latency)
module phasedone_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_phase_shift_sequencer.sv
// pll_phase_shift_sequencer: issues a requested number of phase steps to one
// of PLL_COUNT PLLs, handshaking each step on that PLL's phasedone.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : request strobe (ignored while o_busy)
//   i_pll_sel      : target PLL index; out-of-range index fails the request
//   i_steps        : number of steps; 0 completes at once
//   i_updown       : direction, latched to o_phaseupdown
//   i_cnt_sel      : counter select, latched to o_cntsel
//   i_phasedone    : per-PLL phasedone (asynchronous, synchronised here)
//   o_phasestep    : per-PLL phasestep, only the selected bit ever pulses
//   o_busy         : request in progress
//   o_done/o_error : one-cycle completion / failure pulses
//   o_steps_done   : steps completed in the current or last request
module pll_phase_shift_sequencer
  import pll_phase_shift_sequencer_pkg::*;
#(
  parameter int PLL_COUNT = DEF_PLL_COUNT,
  parameter int STEP_W    = DEF_STEP_W,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int STEP_HOLD = DEF_STEP_HOLD,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [cnt_w(PLL_COUNT)-1:0]   i_pll_sel,
  input  logic [STEP_W-1:0]             i_steps,
  input  logic                          i_updown,
  input  logic [SEL_W-1:0]              i_cnt_sel,
  input  logic [PLL_COUNT-1:0]          i_phasedone,
  output logic [PLL_COUNT-1:0]          o_phasestep,
  output logic                          o_phaseupdown,
  output logic [SEL_W-1:0]              o_cntsel,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic [STEP_W-1:0]             o_steps_done
);

  localparam int PSEL_W = cnt_w(PLL_COUNT);
  localparam int HOLD_W = cnt_w(STEP_HOLD);
  localparam int TMO_W  = cnt_w(TIMEOUT);

  state_e                state_q, state_d;
  logic [PSEL_W-1:0]     pll_q;
  logic [STEP_W-1:0]     steps_q;
  logic                  updown_q;
  logic [SEL_W-1:0]      cnt_q;
  logic [STEP_W-1:0]     steps_done_q;
  logic [HOLD_W-1:0]     hold_q;
  logic [TMO_W-1:0]      tmo_q;
  logic [PLL_COUNT-1:0]  pd_sync;
  logic [PLL_COUNT-1:0]  pll_onehot;
  logic                  pd_sel;
  logic                  sel_ok;
  logic                  hold_last;
  logic                  tmo_last;
  logic                  steps_last;

  phasedone_sync u_sync [PLL_COUNT-1:0] (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_phasedone),
    .q     (pd_sync)
  );

  // Select through a one-hot mask so an out-of-range latched index can never
  // produce an out-of-bounds access; such requests never leave IDLE->FAIL.
  assign pll_onehot = PLL_COUNT'(1) << pll_q;
  assign pd_sel     = |(pd_sync & pll_onehot);
  assign sel_ok     = 32'(i_pll_sel) < PLL_COUNT;
  assign hold_last  = hold_q == HOLD_W'(STEP_HOLD - 1);
  assign tmo_last   = tmo_q == TMO_W'(TIMEOUT - 1);
  assign steps_last = (steps_done_q + STEP_W'(1)) == steps_q;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state. The timeout counter runs across both wait states; on the last
  // allowed cycle the falling edge alone is not enough (the step still needs
  // its rising edge), but a rising edge seen then completes the step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (!sel_ok)                state_d = S_FAIL;
          else if (i_steps == '0)     state_d = S_FINISH;
          else                        state_d = S_STEP;
        end
      end
      S_STEP:      if (hold_last) state_d = S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (tmo_last)     state_d = S_FAIL;
        else if (!pd_sel) state_d = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (pd_sel)        state_d = S_NEXT;
        else if (tmo_last) state_d = S_FAIL;
      end
      S_NEXT:      state_d = steps_last ? S_FINISH : S_STEP;
      S_FINISH:    state_d = S_IDLE;
      S_FAIL:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from state alone so reset removes them immediately.
  always_comb begin
    o_phasestep = '0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_error     = 1'b0;
    if (state_q == S_STEP) o_phasestep = pll_onehot;
    if (state_q != S_IDLE) o_busy      = 1'b1;
    if (state_q == S_FINISH) o_done    = 1'b1;
    if (state_q == S_FAIL)   o_error   = 1'b1;
  end

  // Request fields, step counter, hold and timeout counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pll_q        <= '0;
      steps_q      <= '0;
      updown_q     <= 1'b0;
      cnt_q        <= '0;
      steps_done_q <= '0;
      hold_q       <= '0;
      tmo_q        <= '0;
    end else begin
      if (state_q == S_IDLE && i_start) begin
        pll_q        <= i_pll_sel;
        steps_q      <= i_steps;
        updown_q     <= i_updown;
        cnt_q        <= i_cnt_sel;
        steps_done_q <= '0;
      end
      if (state_q == S_NEXT) steps_done_q <= steps_done_q + STEP_W'(1);
      hold_q <= (state_q == S_STEP) ? hold_q + HOLD_W'(1) : '0;
      tmo_q  <= (state_q == S_WAIT_LOW || state_q == S_WAIT_HIGH) ? tmo_q + TMO_W'(1) : '0;
    end
  end

  assign o_phaseupdown = updown_q;
  assign o_cntsel      = cnt_q;
  assign o_steps_done  = steps_done_q;

endmodule

// File: tb/tb_pll_phase_shift_sequencer.sv
// Bench for pll_phase_shift_sequencer. Each request is turned into a cycle
// timeline (phasestep windows, phasedone stimulus, busy/done/error/count)
// from the step/handshake/timeout rules; a negedge process compares the DUT
// against that timeline every cycle. Directed scenarios add literal checks.
module tb_pll_phase_shift_sequencer;

  localparam int PC   = 4;
  localparam int H    = 2;
  localparam int TO   = 255;
  localparam int MAXC = 600;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] pll_sel;
  logic [7:0] steps;
  logic       updown;
  logic [2:0] cnt_sel;
  logic [3:0] phasedone;
  logic [3:0] phasestep;
  logic       phaseupdown;
  logic [2:0] cntsel;
  logic       busy, done, error;
  logic [7:0] steps_done;

  // 3-PLL instance: a 2-bit select cannot express an index beyond 3, so the
  // out-of-range request is exercised here with index 3.
  logic       start3;
  logic [1:0] pll_sel3;
  logic [2:0] phasedone3;
  logic [2:0] phasestep3;
  logic       phaseupdown3;
  logic [2:0] cntsel3;
  logic       busy3, done3, error3;
  logic [7:0] steps_done3;

  always #5 clk = ~clk;

  pll_phase_shift_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pll_sel(pll_sel),
    .i_steps(steps), .i_updown(updown), .i_cnt_sel(cnt_sel),
    .i_phasedone(phasedone), .o_phasestep(phasestep),
    .o_phaseupdown(phaseupdown), .o_cntsel(cntsel), .o_busy(busy),
    .o_done(done), .o_error(error), .o_steps_done(steps_done)
  );

  pll_phase_shift_sequencer #(.PLL_COUNT(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_pll_sel(pll_sel3),
    .i_steps(steps), .i_updown(updown), .i_cnt_sel(cnt_sel),
    .i_phasedone(phasedone3), .o_phasestep(phasestep3),
    .o_phaseupdown(phaseupdown3), .o_cntsel(cntsel3), .o_busy(busy3),
    .o_done(done3), .o_error(error3), .o_steps_done(steps_done3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected timeline of the request in flight, indexed by cycle offset
  // (offset 0 = the cycle i_start is driven).
  int e_step [MAXC];
  int e_sd   [MAXC];
  bit e_busy [MAXC];
  bit e_done [MAXC];
  bit e_err  [MAXC];
  bit pd_low [MAXC];
  int p_len, p_sd;

  // Persistent expectations between requests
  int m_sd, m_ud, m_cnt;

  // Current expectations read by the compare process
  logic       chk_en;
  logic [3:0] x_step;
  logic       x_busy, x_done, x_err, x_ud;
  logic [7:0] x_sd;
  logic [2:0] x_cnt;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("phasestep",   32'(phasestep),   32'(x_step));
      chk("busy",        32'(busy),        32'(x_busy));
      chk("done",        32'(done),        32'(x_done));
      chk("error",       32'(error),       32'(x_err));
      chk("steps_done",  32'(steps_done),  32'(x_sd));
      chk("phaseupdown", 32'(phaseupdown), 32'(x_ud));
      chk("cntsel",      32'(cntsel),      32'(x_cnt));
    end
  end

  // Build the timeline. Step k starts at cycle s and holds phasestep for H
  // cycles; waiting starts at w = s+H. The PLL drives phasedone low on input
  // cycles [s+d, s+d+l-1]; the sequencer sees inputs 2 cycles late. The fall
  // is seen at max(w, s+d+2), the rise at the first later cycle where the
  // synchronised value is high, and NEXT follows. If the rise is not seen
  // within TO cycles of w, the error pulse lands at w+TO.
  task automatic plan(input int pll, input int nst, input bit stuck,
                      input int fd, input int fl);
    int o, s, w, d, l, cl, ch, n;
    for (int c = 0; c < MAXC; c++) begin
      e_step[c] = 0; e_sd[c] = 0; e_busy[c] = 0;
      e_done[c] = 0; e_err[c] = 0; pd_low[c] = 0;
    end
    if (pll >= PC) begin
      e_busy[1] = 1; e_err[1] = 1; p_len = 2; p_sd = 0; return;
    end
    if (nst == 0) begin
      e_busy[1] = 1; e_done[1] = 1; p_len = 2; p_sd = 0; return;
    end
    o = 1;
    for (int k = 0; k < nst; k++) begin
      d = (fd >= 0) ? fd : int'($urandom_range(0, 6));
      l = (fl > 0)  ? fl : int'($urandom_range(1, 5));
      s = o;
      w = s + H;
      if (!stuck) for (int c = s + d; c < s + d + l; c++) pd_low[c] = 1;
      cl = (s + d + 2 > w) ? s + d + 2 : w;
      ch = (s + d + l + 2 > cl + 1) ? s + d + l + 2 : cl + 1;
      for (int c = s; c < w; c++) e_step[c] = 1 << pll;
      if (stuck || ch > w + TO - 1) begin
        for (int c = s; c <= w + TO; c++) begin e_busy[c] = 1; e_sd[c] = k; end
        e_err[w + TO] = 1;
        p_len = w + TO + 1;
        p_sd  = k;
        return;
      end
      n = ch + 1;
      for (int c = s; c <= n; c++) begin e_busy[c] = 1; e_sd[c] = k; end
      o = n + 1;
    end
    e_busy[o] = 1; e_done[o] = 1; e_sd[o] = nst;
    p_len = o + 1;
    p_sd  = nst;
  endtask

  // Runs one request from #1 after a rising edge. rpl_off re-pulses i_start
  // with other fields at that offset; rst_off asserts reset at that offset.
  task automatic run_req(input int pll, input int nst, input int ud, input int cs,
                         input bit stuck, input int fd, input int fl,
                         input int rpl_off, input int rst_off,
                         output int done_at, output int err_at,
                         output int step_hi, output int n_done);
    logic [3:0] pdv;
    plan(pll, nst, stuck, fd, fl);
    done_at = -1; err_at = -1; step_hi = 0; n_done = 0;
    for (int o = 0; o < p_len + 2; o++) begin
      start = (o == 0) || (o == rpl_off);
      if (o == 0) begin
        pll_sel = 2'(pll); steps = 8'(nst); updown = 1'(ud); cnt_sel = 3'(cs);
      end else if (o == rpl_off) begin
        pll_sel = 2'(pll + 1); steps = 8'(nst + 4); updown = ~updown; cnt_sel = 3'(cs + 1);
      end
      pdv = 4'($urandom);
      if (pll < PC) pdv[pll] = (o < p_len) ? ~pd_low[o] : 1'b1;
      phasedone = pdv;
      if (o == 0) begin
        x_step = '0; x_busy = 0; x_done = 0; x_err = 0;
        x_sd = 8'(m_sd); x_ud = 1'(m_ud); x_cnt = 3'(m_cnt);
      end else if (o < p_len) begin
        x_step = 4'(e_step[o]); x_busy = e_busy[o]; x_done = e_done[o];
        x_err = e_err[o]; x_sd = 8'(e_sd[o]); x_ud = 1'(ud); x_cnt = 3'(cs);
      end else begin
        x_step = '0; x_busy = 0; x_done = 0; x_err = 0;
        x_sd = 8'(p_sd); x_ud = 1'(ud); x_cnt = 3'(cs);
      end
      step_hi += $countones(phasestep);
      if (done)  begin n_done++; done_at = o; end
      if (error) err_at = o;
      if (o == rst_off) begin
        chk("pre_rst_phasestep", 32'(phasestep), 32'(4'b0100));
        chk_en = 0;
        rst_n  = 0;
        start  = 0;
        #1;
        chk("rst_phasestep_now", 32'(phasestep), 0);
        chk("rst_busy_now",      32'(busy),      0);
        for (int r = 0; r < 3; r++) begin
          @(posedge clk); #1;
          chk("rst_no_done",   32'(done),       0);
          chk("rst_no_error",  32'(error),      0);
          chk("rst_steps_clr", 32'(steps_done), 0);
          chk("rst_cntsel_clr", 32'(cntsel),    0);
        end
        rst_n = 1;
        m_sd = 0; m_ud = 0; m_cnt = 0;
        x_step = '0; x_busy = 0; x_done = 0; x_err = 0; x_sd = '0; x_ud = 0; x_cnt = '0;
        chk_en = 1;
        return;
      end
      @(posedge clk); #1;
    end
    start = 0;
    m_sd = p_sd; m_ud = ud; m_cnt = cs;
  endtask

  int da, ea, sh, nd;

  initial begin
    rst_n = 0; start = 0; pll_sel = '0; steps = '0; updown = 0; cnt_sel = '0;
    phasedone = '1; start3 = 0; pll_sel3 = '0; phasedone3 = '1;
    m_sd = 0; m_ud = 0; m_cnt = 0; chk_en = 0;
    x_step = '0; x_busy = 0; x_done = 0; x_err = 0; x_sd = '0; x_ud = 0; x_cnt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_phasestep",   32'(phasestep),   0);
    chk("reset_busy",        32'(busy),        0);
    chk("reset_done",        32'(done),        0);
    chk("reset_error",       32'(error),       0);
    chk("reset_steps_done",  32'(steps_done),  0);
    chk("reset_phaseupdown", 32'(phaseupdown), 0);
    chk("reset_cntsel",      32'(cntsel),      0);
    rst_n  = 1;
    chk_en = 1;

    // 3 steps on PLL1, phasedone low for 3 cycles starting 2 cycles after
    // each step: 9 cycles per step, done pulse at offset 28.
    run_req(1, 3, 1, 5, 0, 2, 3, -1, -1, da, ea, sh, nd);
    chk("s1_done_at",     32'(da), 28);
    chk("s1_step_cycles", 32'(sh), 6);
    chk("s1_done_pulses", 32'(nd), 1);
    chk("s1_no_error",    32'(ea), 32'(-1));
    chk("s1_steps_done",  32'(steps_done), 3);

    // Zero steps: done right after acceptance, no phasestep.
    run_req(0, 0, 0, 2, 0, 2, 3, -1, -1, da, ea, sh, nd);
    chk("s2_done_at",     32'(da), 1);
    chk("s2_step_cycles", 32'(sh), 0);
    chk("s2_steps_done",  32'(steps_done), 0);

    // phasedone stuck high: WAIT_LOW entered at offset 3, error at 3+255.
    run_req(2, 2, 1, 3, 1, 0, 0, -1, -1, da, ea, sh, nd);
    chk("s3_error_at",    32'(ea), 258);
    chk("s3_no_done",     32'(nd), 0);
    chk("s3_step_cycles", 32'(sh), 2);
    chk("s3_steps_done",  32'(steps_done), 0);

    // Reset in the middle of step 2 of 4 (step 2 spans offsets 10..11).
    run_req(2, 4, 1, 4, 0, 2, 3, -1, 11, da, ea, sh, nd);
    chk("s4_no_done_before_rst", 32'(nd), 0);
    run_req(3, 2, 0, 2, 0, 2, 3, -1, -1, da, ea, sh, nd);
    chk("s4_fresh_done_at",    32'(da), 19);
    chk("s4_fresh_steps_done", 32'(steps_done), 2);

    // Start re-pulsed while busy with other fields: must be ignored.
    run_req(0, 3, 0, 6, 0, 2, 3, 4, -1, da, ea, sh, nd);
    chk("s5_done_at",     32'(da), 28);
    chk("s5_done_pulses", 32'(nd), 1);
    chk("s5_steps_done",  32'(steps_done), 3);
    chk("s5_cntsel",      32'(cntsel), 6);

    // Out-of-range PLL index on the 3-PLL instance.
    pll_sel3 = 2'd3; steps = 8'd5; start3 = 1;
    @(posedge clk); #1;
    start3 = 0;
    chk("s6_error",     32'(error3),     1);
    chk("s6_busy",      32'(busy3),      1);
    chk("s6_phasestep", 32'(phasestep3), 0);
    chk("s6_no_done",   32'(done3),      0);
    @(posedge clk); #1;
    chk("s6_error_gone", 32'(error3),      0);
    chk("s6_idle",       32'(busy3),       0);
    chk("s6_steps_done", 32'(steps_done3), 0);

    // Randomised requests against the timeline model.
    for (int i = 0; i < 30; i++) begin
      run_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
              0, -1, 0, ($urandom_range(0, 3) == 0) ? 3 : -1, -1,
              da, ea, sh, nd);
      chk("rand_no_error", 32'(ea), 32'(-1));
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
